// File: rtl/hls_deadlock_multi_monitor.sv
// hls_deadlock_multi_monitor
//   Watches an HLS top level for a persistent blocked condition and latches a sticky
//   deadlock flag together with a snapshot of the blocking sources.
//
// Ports
//   i_clock            clock, all logic on the rising edge
//   i_reset            synchronous active-high reset
//   i_axis_block_sigs  per-AXIS-port blocked
//   i_inst_idle_sigs   per-instance idle
//   i_inst_block_sigs  per-instance blocked
//   i_threshold        persistence cycles needed to confirm (0 behaves as 1)
//   i_clear            pulse, clears all sticky state
//   o_block            raw block condition, registered
//   o_deadlock         sticky confirmed deadlock
//   o_axis_snap        AXIS block inputs captured at confirmation
//   o_inst_snap        instance block inputs captured at confirmation
//   o_first_idx        source that opened the suspect window (AXIS first, then instances)
//   o_persist_cnt      current persistence count, saturating
module hls_deadlock_multi_monitor #(
  parameter int unsigned N_AXIS = 4,
  parameter int unsigned N_INST = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned IDX_W  = (N_AXIS + N_INST > 1) ? $clog2(N_AXIS + N_INST) : 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [N_AXIS-1:0] i_axis_block_sigs,
  input  logic [N_INST-1:0] i_inst_idle_sigs,
  input  logic [N_INST-1:0] i_inst_block_sigs,
  input  logic [CNT_W-1:0]  i_threshold,
  input  logic              i_clear,
  output logic              o_block,
  output logic              o_deadlock,
  output logic [N_AXIS-1:0] o_axis_snap,
  output logic [N_INST-1:0] o_inst_snap,
  output logic [IDX_W-1:0]  o_first_idx,
  output logic [CNT_W-1:0]  o_persist_cnt
);

  typedef enum logic [1:0] {StIdle, StSuspect, StDeadlock} state_e;

  state_e              r_state, w_state;
  logic                r_block, w_block;
  logic                r_deadlock, w_deadlock;
  logic [N_AXIS-1:0]   r_axis_snap, w_axis_snap;
  logic [N_INST-1:0]   r_inst_snap, w_inst_snap;
  logic [IDX_W-1:0]    r_first_idx, w_first_idx;
  logic [CNT_W-1:0]    r_cnt, w_cnt;

  logic                w_inst_seq;
  logic                w_raw;
  logic [CNT_W-1:0]    w_thr;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [IDX_W-1:0]    w_lowest_idx;

  // Condition decode, effective threshold and lowest blocking source.
  always_comb begin
    w_inst_seq = (&(i_inst_idle_sigs | i_inst_block_sigs)) & (|i_inst_block_sigs);
    w_raw      = (|i_axis_block_sigs) | w_inst_seq;
    w_thr      = (i_threshold == '0) ? CNT_W'(1) : i_threshold;
    w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Scan high to low so the lowest index wins; AXIS sources take priority.
    w_lowest_idx = '0;
    for (int i = int'(N_INST) - 1; i >= 0; i--) begin
      if (w_inst_seq && i_inst_block_sigs[i]) w_lowest_idx = IDX_W'(int'(N_AXIS) + i);
    end
    for (int i = int'(N_AXIS) - 1; i >= 0; i--) begin
      if (i_axis_block_sigs[i]) w_lowest_idx = IDX_W'(i);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_block     = w_raw;
    w_deadlock  = r_deadlock;
    w_axis_snap = r_axis_snap;
    w_inst_snap = r_inst_snap;
    w_first_idx = r_first_idx;
    w_cnt       = r_cnt;

    unique case (r_state)
      StIdle: begin
        if (w_raw) begin
          w_cnt       = CNT_W'(1);
          w_first_idx = w_lowest_idx;
          if (w_thr == CNT_W'(1)) begin
            w_state     = StDeadlock;
            w_deadlock  = 1'b1;
            w_axis_snap = i_axis_block_sigs;
            w_inst_snap = i_inst_block_sigs;
          end else begin
            w_state = StSuspect;
          end
        end
      end
      StSuspect: begin
        if (!w_raw) begin
          w_state = StIdle;
          w_cnt   = '0;
        end else begin
          w_cnt = w_cnt_inc;
          // Also catches a threshold lowered below the running count.
          if (w_cnt_inc >= w_thr) begin
            w_state     = StDeadlock;
            w_deadlock  = 1'b1;
            w_axis_snap = i_axis_block_sigs;
            w_inst_snap = i_inst_block_sigs;
          end
        end
      end
      StDeadlock: begin
        if (w_raw) w_cnt = w_cnt_inc;
      end
      default: begin
        w_state = StIdle;
      end
    endcase

    // Clear beats any simultaneous entry or confirmation; block is unaffected.
    if (i_clear) begin
      w_state     = StIdle;
      w_deadlock  = 1'b0;
      w_axis_snap = '0;
      w_inst_snap = '0;
      w_first_idx = '0;
      w_cnt       = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_block     <= 1'b0;
      r_deadlock  <= 1'b0;
      r_axis_snap <= '0;
      r_inst_snap <= '0;
      r_first_idx <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_block     <= w_block;
      r_deadlock  <= w_deadlock;
      r_axis_snap <= w_axis_snap;
      r_inst_snap <= w_inst_snap;
      r_first_idx <= w_first_idx;
      r_cnt       <= w_cnt;
    end
  end

  assign o_block       = r_block;
  assign o_deadlock    = r_deadlock;
  assign o_axis_snap   = r_axis_snap;
  assign o_inst_snap   = r_inst_snap;
  assign o_first_idx   = r_first_idx;
  assign o_persist_cnt = r_cnt;

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Self-checking bench for hls_deadlock_multi_monitor: directed scenarios followed by
// randomized traffic, all compared each cycle against a behavioural model.
module tb_hls_deadlock_multi_monitor;

  localparam int NA   = 4;
  localparam int NI   = 4;
  localparam int CW   = 4;
  localparam int IW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [NA-1:0] axis;
  logic [NI-1:0] idle;
  logic [NI-1:0] blk;
  logic [CW-1:0] thr;
  logic          clr;
  logic          o_block;
  logic          o_deadlock;
  logic [NA-1:0] o_axis_snap;
  logic [NI-1:0] o_inst_snap;
  logic [IW-1:0] o_first_idx;
  logic [CW-1:0] o_persist_cnt;

  int n_checks;
  int n_fail;

  // Model state: a nonzero count outside deadlock means a suspect window is open.
  int m_block, m_deadlock, m_cnt, m_first, m_asnap, m_isnap;

  hls_deadlock_multi_monitor #(
    .N_AXIS(NA),
    .N_INST(NI),
    .CNT_W (CW),
    .IDX_W (IW)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_axis_block_sigs(axis),
    .i_inst_idle_sigs (idle),
    .i_inst_block_sigs(blk),
    .i_threshold      (thr),
    .i_clear          (clr),
    .o_block          (o_block),
    .o_deadlock       (o_deadlock),
    .o_axis_snap      (o_axis_snap),
    .o_inst_snap      (o_inst_snap),
    .o_first_idx      (o_first_idx),
    .o_persist_cnt    (o_persist_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  all_ok, any_blk, seq, raw, first, need;
    all_ok  = 1;
    any_blk = 0;
    for (int j = 0; j < NI; j++) begin
      if (!(idle[j] || blk[j])) all_ok = 0;
      if (blk[j]) any_blk = 1;
    end
    seq = all_ok && any_blk;
    raw = (axis != 0) || seq;
    first = -1;
    for (int i = 0; i < NA; i++) if (first < 0 && axis[i]) first = i;
    if (first < 0) for (int j = 0; j < NI; j++) if (first < 0 && blk[j]) first = NA + j;
    need = (thr == 0) ? 1 : int'(thr);

    if (rst) begin
      m_block = 0; m_deadlock = 0; m_cnt = 0; m_first = 0; m_asnap = 0; m_isnap = 0;
    end else if (clr) begin
      m_block = raw; m_deadlock = 0; m_cnt = 0; m_first = 0; m_asnap = 0; m_isnap = 0;
    end else begin
      m_block = raw;
      if (m_deadlock != 0) begin
        if (raw) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else if (raw) begin
        if (m_cnt == 0) begin
          m_first = first;
          m_cnt   = 1;
        end else begin
          m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
        if (m_cnt >= need) begin
          m_deadlock = 1;
          m_asnap    = int'(axis);
          m_isnap    = int'(blk);
        end
      end else begin
        m_cnt = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("block", o_block, m_block);
    check_val("deadlock", o_deadlock, m_deadlock);
    check_val("persist_cnt", o_persist_cnt, m_cnt);
    check_val("first_idx", o_first_idx, m_first);
    check_val("axis_snap", o_axis_snap, m_asnap);
    check_val("inst_snap", o_inst_snap, m_isnap);
  endtask

  task automatic step(input logic [NA-1:0] a, input logic [NI-1:0] id, input logic [NI-1:0] b,
                      input logic [CW-1:0] t, input logic c, input logic r);
    axis = a; idle = id; blk = b; thr = t; clr = c; rst = r;
    cycle();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_block = 0; m_deadlock = 0; m_cnt = 0; m_first = 0; m_asnap = 0; m_isnap = 0;
    axis = '0; idle = '0; blk = '0; thr = '0; clr = 1'b0; rst = 1'b1;

    // Reset then quiet inputs.
    repeat (2) step(4'b0, 4'b0, 4'b0, 4'd0, 1'b0, 1'b1);
    repeat (20) step(4'b0, 4'b0, 4'b0, 4'd0, 1'b0, 1'b0);
    check_val("quiet_deadlock", o_deadlock, 0);

    // Single AXIS port blocked, threshold 5.
    repeat (4) step(4'b0100, 4'b0, 4'b0, 4'd5, 1'b0, 1'b0);
    check_val("s2_pre_deadlock", o_deadlock, 0);
    step(4'b0100, 4'b0, 4'b0, 4'd5, 1'b0, 1'b0);
    check_val("s2_deadlock", o_deadlock, 1);
    check_val("s2_axis_snap", o_axis_snap, 4'b0100);
    check_val("s2_first_idx", o_first_idx, 2);
    step(4'b0, 4'b0, 4'b0, 4'd5, 1'b1, 1'b0);
    check_val("s2_cleared", o_deadlock, 0);

    // Short block burst falls back to idle.
    repeat (3) step(4'b0001, 4'b0, 4'b0, 4'd5, 1'b0, 1'b0);
    step(4'b0, 4'b0, 4'b0, 4'd5, 1'b0, 1'b0);
    check_val("s3_cnt", o_persist_cnt, 0);
    check_val("s3_deadlock", o_deadlock, 0);

    // Instance-sequence block with threshold 1.
    step(4'b0, 4'b1101, 4'b0010, 4'd1, 1'b0, 1'b0);
    check_val("s4_deadlock", o_deadlock, 1);
    check_val("s4_first_idx", o_first_idx, NA + 1);
    check_val("s4_inst_snap", o_inst_snap, 4'b0010);
    step(4'b0, 4'b0, 4'b0, 4'd1, 1'b1, 1'b0);
    step(4'b0, 4'b0101, 4'b0010, 4'd1, 1'b0, 1'b0);
    check_val("s4_noseq_block", o_block, 0);

    // Clear while blocked, then re-confirm after 3 raw cycles.
    step(4'b0, 4'b1101, 4'b0010, 4'd1, 1'b0, 1'b0);
    step(4'b1000, 4'b0, 4'b0, 4'd3, 1'b1, 1'b0);
    check_val("s5_clr_deadlock", o_deadlock, 0);
    check_val("s5_clr_cnt", o_persist_cnt, 0);
    repeat (2) step(4'b1000, 4'b0, 4'b0, 4'd3, 1'b0, 1'b0);
    check_val("s5_pre_deadlock", o_deadlock, 0);
    step(4'b1000, 4'b0, 4'b0, 4'd3, 1'b0, 1'b0);
    check_val("s5_redeadlock", o_deadlock, 1);
    step(4'b0, 4'b0, 4'b0, 4'd3, 1'b1, 1'b0);

    // Threshold 0, long run, saturation and mid-run reset.
    step(4'b0001, 4'b0, 4'b0, 4'd0, 1'b0, 1'b0);
    check_val("s6_first_deadlock", o_deadlock, 1);
    repeat (19) step(4'b0001, 4'b0, 4'b0, 4'd0, 1'b0, 1'b0);
    check_val("s6_saturated", o_persist_cnt, CMAX);
    step(4'b0001, 4'b0, 4'b0, 4'd0, 1'b0, 1'b1);
    check_val("s6_reset_deadlock", o_deadlock, 0);
    check_val("s6_reset_block", o_block, 0);
    repeat (20) step(4'b0001, 4'b0, 4'b0, 4'd0, 1'b0, 1'b0);
    check_val("s6_resat", o_persist_cnt, CMAX);
    step(4'b0, 4'b0, 4'b0, 4'd0, 1'b1, 1'b0);

    // Randomized traffic: inputs held for random spans so suspect windows form.
    for (int seg = 0; seg < 4; seg++) begin
      int cyc;
      cyc = 0;
      while (cyc < 200) begin
        logic [NA-1:0] a;
        logic [NI-1:0] id, b;
        logic [CW-1:0] t;
        int hold;
        a    = ($urandom_range(0, 3) <= seg) ? NA'($urandom) : '0;
        b    = NI'($urandom);
        id   = NI'($urandom) | NI'($urandom);
        t    = CW'($urandom_range(0, 7));
        hold = $urandom_range(1, 8);
        for (int h = 0; h < hold; h++) begin
          step(a, id, b, t, ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
          cyc++;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
